// File: rtl/drawing_pkg.sv
// Shared constants and FSM encoding for the drawing-module datapath blocks.
package drawing_pkg;
  localparam int SPRITE_SIZE = 20;
  localparam int COLOR_W     = 9;
  localparam int ADDR_W      = 14;
  localparam int IDX_W       = 5;
  localparam int COORD_W     = 10;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 9'h1FF;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_ADDR = 3'd1,
    ST_READ = 3'd2,
    ST_SHOW = 3'd3,
    ST_GAP  = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Sprite-memory read bus: registered address out, synchronous-read data back.
interface sprite_pixel_fetch_if;
  import drawing_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/sprite_addr_calc.sv
// Combinational sprite hit test and sprite-memory address (idx*400 + dy*20 + dx).
module sprite_addr_calc
  import drawing_pkg::*;
(
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [IDX_W-1:0]   sprite_idx,
  input  logic               sprite_en,
  output logic               in_box,
  output logic [ADDR_W-1:0]  addr
);
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [ADDR_W-1:0]  idx_ext;
  logic [ADDR_W-1:0]  dx_ext;
  logic [ADDR_W-1:0]  dy_ext;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  row;

  assign dx = pixel_x - sprite_x;
  assign dy = pixel_y - sprite_y;

  assign idx_ext = ADDR_W'(sprite_idx);
  assign dx_ext  = ADDR_W'(dx);
  assign dy_ext  = ADDR_W'(dy);

  // 400 = 256 + 128 + 16, 20 = 16 + 4
  assign base = (idx_ext << 8) + (idx_ext << 7) + (idx_ext << 4);
  assign row  = (dy_ext << 4) + (dy_ext << 2);
  assign addr = base + row + dx_ext;

  // The >= terms stop an unsigned wrap of dx/dy from looking like a hit.
  assign in_box = sprite_en
                  && (pixel_x >= sprite_x) && (pixel_y >= sprite_y)
                  && (dx < COORD_W'(SPRITE_SIZE)) && (dy < COORD_W'(SPRITE_SIZE));
endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: follows the two-phase refresh strobes, fetches the sprite
// colour and registers the final pixel; flags strobe-sequence violations.
//
// state | meaning
// WAIT  | idle after reset or after a protocol violation
// ADDR  | first data cycle, sample coordinates and compute address
// READ  | second data cycle, memory address stable
// SHOW  | vga cycle, memory data valid, colour chosen at end of cycle
// GAP   | idle between pixels, waiting for next data strobe
module sprite_pixel_fetch
  import drawing_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refresh_data_in,
  input  logic                 refresh_vga_in,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 video_on,
  input  logic [COORD_W-1:0]   sprite_x,
  input  logic [COORD_W-1:0]   sprite_y,
  input  logic [IDX_W-1:0]     sprite_idx,
  input  logic                 sprite_en,
  input  logic [COLOR_W-1:0]   bg_color,
  sprite_pixel_fetch_if.master mem,
  output logic [COLOR_W-1:0]   rgb_out,
  output logic                 protocol_error
);
  fetch_state_t       state;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_calc;
  logic               in_box_q;
  logic               video_on_q;
  logic [COLOR_W-1:0] bg_q;
  logic [COLOR_W-1:0] shade;
  logic               data_only;
  logic               vga_only;
  logic               idle;

  sprite_addr_calc u_addr_calc (
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_idx (sprite_idx),
    .sprite_en  (sprite_en),
    .in_box     (in_box),
    .addr       (addr_calc)
  );

  assign data_only = refresh_data_in & ~refresh_vga_in;
  assign vga_only  = ~refresh_data_in & refresh_vga_in;
  assign idle      = ~refresh_data_in & ~refresh_vga_in;

  always_comb begin
    shade = mem.mem_data;
    if (!video_on_q)
      shade = '0;
    else if (!in_box_q || (mem.mem_data == TRANSPARENT))
      shade = bg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_WAIT;
      mem.mem_addr   <= '0;
      in_box_q       <= 1'b0;
      video_on_q     <= 1'b0;
      bg_q           <= '0;
      rgb_out        <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (data_only) begin
            state <= ST_ADDR;
          end else if (!idle) begin
            protocol_error <= 1'b1;
            state          <= ST_WAIT;
          end
        end
        ST_ADDR: begin
          if (data_only) begin
            state      <= ST_READ;
            in_box_q   <= in_box;
            video_on_q <= video_on;
            bg_q       <= bg_color;
            if (in_box)
              mem.mem_addr <= addr_calc;
          end else begin
            protocol_error <= 1'b1;
            state          <= ST_WAIT;
          end
        end
        ST_READ: begin
          if (vga_only) begin
            state <= ST_SHOW;
          end else begin
            protocol_error <= 1'b1;
            state          <= ST_WAIT;
          end
        end
        ST_SHOW: begin
          if (idle) begin
            state   <= ST_GAP;
            rgb_out <= shade;
          end else begin
            protocol_error <= 1'b1;
            state          <= ST_WAIT;
          end
        end
        ST_GAP: begin
          if (data_only) begin
            state <= ST_ADDR;
          end else if (!idle) begin
            protocol_error <= 1'b1;
            state          <= ST_WAIT;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a synchronous-read sprite memory model.
module tb_sprite_pixel_fetch;
  import drawing_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               data;
  logic               vga;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_on;
  logic [COORD_W-1:0] sprite_x;
  logic [COORD_W-1:0] sprite_y;
  logic [IDX_W-1:0]   sprite_idx;
  logic               sprite_en;
  logic [COLOR_W-1:0] bg_color;
  logic [COLOR_W-1:0] rgb_out;
  logic               protocol_error;

  logic [COLOR_W-1:0] sprite_mem [0:16383];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sprite_pixel_fetch_if mem_bus ();

  always @(posedge clk) mem_bus.mem_data <= sprite_mem[mem_bus.mem_addr];

  sprite_pixel_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .refresh_data_in (data),
    .refresh_vga_in  (vga),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .video_on        (video_on),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .sprite_idx      (sprite_idx),
    .sprite_en       (sprite_en),
    .bg_color        (bg_color),
    .mem             (mem_bus.master),
    .rgb_out         (rgb_out),
    .protocol_error  (protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One nominal strobe period; coordinates are scrambled after the sampling edge.
  task automatic run_pixel(input string tag, input logic [9:0] px, input logic [9:0] py,
                           input logic von, input logic [8:0] bg,
                           input logic [31:0] exp_addr, input logic [31:0] exp_rgb);
    pixel_x = px; pixel_y = py; video_on = von; bg_color = bg;
    data = 1'b1; vga = 1'b0;
    tick();
    tick();
    check({tag, "_addr"}, 32'(mem_bus.mem_addr), exp_addr);
    pixel_x = 10'd0; pixel_y = 10'd0; video_on = ~von; bg_color = ~bg;
    data = 1'b0; vga = 1'b1;
    tick();
    vga = 1'b0;
    tick();
    check({tag, "_rgb"}, 32'(rgb_out), exp_rgb);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sprite_mem[i] = '0;
    sprite_mem[1245]  = 9'h0A5;
    sprite_mem[1221]  = 9'h1FF;
    sprite_mem[1599]  = 9'h0F0;
    sprite_mem[12799] = 9'h155;

    reset = 1'b0; data = 1'b0; vga = 1'b0;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_idx = 5'd3; sprite_en = 1'b1;
    bg_color = '0;
    tick();
    tick();
    check("rst_rgb",  32'(rgb_out), 32'h0);
    check("rst_addr", 32'(mem_bus.mem_addr), 32'h0);
    check("rst_perr", 32'(protocol_error), 32'h0);
    check("rst_state", 32'(dut.state), 32'(ST_WAIT));
    reset = 1'b1;
    tick();

    run_pixel("nominal", 10'd105, 10'd52, 1'b1, 9'h049, 32'd1245, 32'h0A5);
    check("nominal_perr", 32'(protocol_error), 32'h0);
    run_pixel("outside", 10'd120, 10'd52, 1'b1, 9'h049, 32'd1245, 32'h049);
    run_pixel("transp", 10'd101, 10'd51, 1'b1, 9'h123, 32'd1221, 32'h123);
    run_pixel("blank", 10'd105, 10'd52, 1'b0, 9'h049, 32'd1245, 32'h0);
    run_pixel("corner", 10'd119, 10'd69, 1'b1, 9'h049, 32'd1599, 32'h0F0);
    run_pixel("left_of", 10'd99, 10'd50, 1'b1, 9'h0AA, 32'd1599, 32'h0AA);
    sprite_idx = 5'd31;
    run_pixel("last_word", 10'd119, 10'd69, 1'b1, 9'h049, 32'd12799, 32'h155);
    tick(); tick(); tick();
    check("hold_rgb", 32'(rgb_out), 32'h155);

    // vga strobe after a single data cycle
    data = 1'b1;
    tick();
    data = 1'b0; vga = 1'b1;
    tick();
    check("early_vga_perr", 32'(protocol_error), 32'h1);
    check("early_vga_state", 32'(dut.state), 32'(ST_WAIT));
    check("early_vga_rgb", 32'(rgb_out), 32'h155);
    vga = 1'b0;
    tick();

    // reset asserted during READ
    sprite_idx = 5'd3;
    pixel_x = 10'd105; pixel_y = 10'd52; video_on = 1'b1;
    data = 1'b1;
    tick();
    tick();
    check("pre_reset_state", 32'(dut.state), 32'(ST_READ));
    reset = 1'b0;
    #1;
    check("areset_rgb", 32'(rgb_out), 32'h0);
    check("areset_addr", 32'(mem_bus.mem_addr), 32'h0);
    check("areset_perr", 32'(protocol_error), 32'h0);
    check("areset_state", 32'(dut.state), 32'(ST_WAIT));
    data = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_pixel("post_reset", 10'd105, 10'd52, 1'b1, 9'h049, 32'd1245, 32'h0A5);
    check("post_reset_perr", 32'(protocol_error), 32'h0);

    // both strobes high
    data = 1'b1; vga = 1'b1;
    tick();
    check("both_perr", 32'(protocol_error), 32'h1);
    check("both_state", 32'(dut.state), 32'(ST_WAIT));
    check("both_rgb", 32'(rgb_out), 32'h0A5);
    data = 1'b0; vga = 1'b0;
    tick();

    sprite_idx = 5'd31;
    run_pixel("sticky", 10'd119, 10'd69, 1'b1, 9'h049, 32'd12799, 32'h155);
    check("sticky_perr", 32'(protocol_error), 32'h1);

    // third consecutive data cycle
    data = 1'b1;
    tick(); tick(); tick();
    check("third_data_state", 32'(dut.state), 32'(ST_WAIT));
    check("third_data_rgb", 32'(rgb_out), 32'h155);
    data = 1'b0;
    tick();

    // data strobe during SHOW must not update the pixel
    sprite_idx = 5'd3;
    pixel_x = 10'd101; pixel_y = 10'd51; bg_color = 9'h123;
    data = 1'b1;
    tick(); tick();
    data = 1'b0; vga = 1'b1;
    tick();
    data = 1'b1; vga = 1'b0;
    tick();
    check("show_data_state", 32'(dut.state), 32'(ST_ADDR) & 32'h0 | 32'(ST_WAIT));
    check("show_data_rgb", 32'(rgb_out), 32'h155);
    data = 1'b0;
    tick();
    check("final_perr", 32'(protocol_error), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
